issue_queue: RTL

- Dual-issue instruction queue between fetch and decode.
- Accepts up to two instruction words per cycle from fetch, together with their PCs.
- Each cycle, presents the oldest one or two entries to decode as an issue pair.
- Slot 2 is issued only when the pair is free of intra-pair hazards; the decode stage never has to check pairing legality itself.

---
 rtl/riscv_pkg.sv | 61 ++++++
 rtl/issue_pair_check.sv | 42 ++++
 rtl/issue_queue.sv | 119 +++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 decode constants, queue entry type and register-usage helpers
// for the fetch/decode issue queue.
package riscv_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } iq_entry_t;

  function automatic logic writes_rd(input logic [6:0] opc);
    case (opc)
      OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_LUI,
      OPC_AUIPC, OPC_JAL, OPC_JALR: writes_rd = 1'b1;
      default:                      writes_rd = 1'b0;
    endcase
  endfunction

  // Unknown opcodes conservatively read both source registers.
  function automatic logic reads_rs1(input logic [6:0] opc);
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL: reads_rs1 = 1'b0;
      default:                     reads_rs1 = 1'b1;
    endcase
  endfunction

  function automatic logic reads_rs2(input logic [6:0] opc);
    case (opc)
      OPC_OP, OPC_STORE, OPC_BRANCH:  reads_rs2 = 1'b1;
      OPC_OP_IMM, OPC_LOAD, OPC_LUI,
      OPC_AUIPC, OPC_JAL, OPC_JALR:   reads_rs2 = 1'b0;
      default:                        reads_rs2 = 1'b1;
    endcase
  endfunction

  function automatic logic is_mem(input logic [6:0] opc);
    case (opc)
      OPC_LOAD, OPC_STORE: is_mem = 1'b1;
      default:             is_mem = 1'b0;
    endcase
  endfunction

  function automatic logic is_ctrl(input logic [6:0] opc);
    case (opc)
      OPC_BRANCH, OPC_JAL, OPC_JALR: is_ctrl = 1'b1;
      default:                       is_ctrl = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/issue_pair_check.sv
// Combinational pairing check: pair_ok is high when the younger word i2 may
// issue alongside the older word i1 in the same cycle.
module issue_pair_check
  import riscv_pkg::*;
(
  input  logic [31:0] i1,
  input  logic [31:0] i2,
  output logic        pair_ok
);

  logic [6:0] opc1_s;
  logic [6:0] opc2_s;
  logic [4:0] rd1_s;
  logic [4:0] rd2_s;
  logic [4:0] rs1_s;
  logic [4:0] rs2_s;
  logic       dep_s;
  logic       hazard_s;

  assign opc1_s = i1[6:0];
  assign opc2_s = i2[6:0];
  assign rd1_s  = i1[11:7];
  assign rd2_s  = i2[11:7];
  assign rs1_s  = i2[19:15];
  assign rs2_s  = i2[24:20];

  // Control transfer in i1, shared memory port, or a register dependency on i1.rd.
  always_comb begin
    dep_s    = 1'b0;
    hazard_s = 1'b0;
    if (writes_rd(opc1_s) && (rd1_s != 5'd0)) begin
      dep_s = (reads_rs1(opc2_s) && (rs1_s == rd1_s)) ||
              (reads_rs2(opc2_s) && (rs2_s == rd1_s)) ||
              (writes_rd(opc2_s) && (rd2_s == rd1_s));
    end else begin
      dep_s = 1'b0;
    end
    hazard_s = is_ctrl(opc1_s) || (is_mem(opc1_s) && is_mem(opc2_s)) || dep_s;
    pair_ok  = !hazard_s;
  end

endmodule

// File: rtl/issue_queue.sv
// Dual-issue circular instruction queue between fetch and decode. Slot outputs
// and FetchReadyF depend only on registered state.
module issue_queue
  import riscv_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  FetchValidF,
  input  logic [31:0] InstrF1,
  input  logic [31:0] InstrF2,
  input  logic [31:0] PCF,
  output logic        FetchReadyF,
  input  logic        StallD,
  input  logic        FlushD,
  output logic [31:0] InstrD1,
  output logic [31:0] InstrD2,
  output logic [31:0] PCD1,
  output logic [31:0] PCD2,
  output logic        ValidD1,
  output logic        ValidD2
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;
  iq_entry_t     mem_r [DEPTH];

  iq_entry_t     head_s;
  iq_entry_t     next_s;
  logic          pair_ok_s;
  logic          push_en_s;
  logic [1:0]    push_n_s;
  logic [1:0]    pop_n_s;

  assign head_s = mem_r[rd_ptr_r];
  assign next_s = mem_r[rd_ptr_r + PTR_ONE];

  issue_pair_check u_pair_check (
    .i1      (head_s.instr),
    .i2      (next_s.instr),
    .pair_ok (pair_ok_s)
  );

  // Issue slots and fetch back-pressure from registered state.
  always_comb begin
    FetchReadyF = (count_r <= CW'(DEPTH - 2));
    ValidD1     = (count_r != {CW{1'b0}});
    ValidD2     = ValidD1 && (count_r >= CW'(2)) && pair_ok_s;
    InstrD1     = NOP;
    PCD1        = 32'd0;
    InstrD2     = NOP;
    PCD2        = 32'd0;
    if (ValidD1) begin
      InstrD1 = head_s.instr;
      PCD1    = head_s.pc;
    end else begin
      InstrD1 = NOP;
      PCD1    = 32'd0;
    end
    if (ValidD2) begin
      InstrD2 = next_s.instr;
      PCD2    = next_s.pc;
    end else begin
      InstrD2 = NOP;
      PCD2    = 32'd0;
    end
  end

  // Per-cycle push and pop amounts.
  always_comb begin
    push_en_s = FetchReadyF && !FlushD;
    push_n_s  = 2'd0;
    pop_n_s   = 2'd0;
    if (push_en_s) begin
      push_n_s = {1'b0, FetchValidF[0]} + {1'b0, FetchValidF[1]};
    end else begin
      push_n_s = 2'd0;
    end
    if (StallD) begin
      pop_n_s = 2'd0;
    end else begin
      pop_n_s = {1'b0, ValidD1} + {1'b0, ValidD2};
    end
  end

  // Pointer and occupancy state; flush wins over any push or pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (FlushD) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      rd_ptr_r <= rd_ptr_r + PW'(pop_n_s);
      wr_ptr_r <= wr_ptr_r + PW'(push_n_s);
      count_r  <= count_r + CW'(push_n_s) - CW'(pop_n_s);
    end
  end

  // Entry storage needs no reset: contents are only observed under a valid count.
  always_ff @(posedge clk) begin
    if (push_en_s && FetchValidF[0]) begin
      mem_r[wr_ptr_r] <= '{instr: InstrF1, pc: PCF};
    end
    if (push_en_s && FetchValidF[1]) begin
      mem_r[wr_ptr_r + PTR_ONE] <= '{instr: InstrF2, pc: PCF + 32'd4};
    end
  end

endmodule
